// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract unit.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1; used as clog2(WIDTH+1) for the bit counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_sub_badd.sv
// One-bit full-adder cell.
module bAdd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CW-1:0]    cnt;
  logic             cy, s_bit, co_bit;
  logic             accept, last;

  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

  bAdd u_badd (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy),
    .s  (s_bit),
    .co (co_bit)
  );

  // New bit enters at the MSB end so the final shift leaves bit 0 at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = s_bit;
    end else begin : g_wn
      assign res_nxt = {s_bit, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Working shift registers are private; sum/c_out/overflow load only when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b ^ {WIDTH{sub}};
      cy   <= sub;
      cnt  <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      cy     <= co_bit;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum      <= res_nxt;
        c_out    <= co_bit;
        overflow <= cy ^ co_bit;
      end
    end
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; operands and mode are captured at the edge where start=1 and the block is accepting.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b (two's complement).
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 busy  output  1  high while bit-serial computation is in progress.
REQ-009 done  output  1  single-cycle pulse; result is valid from this cycle on.
REQ-010 sum  output  WIDTH  result, held stable until the next accepted start.
REQ-011 c_out  output  1  carry out of the MSB; for sub=1, 1 = no borrow.
REQ-012 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 FSM states IDLE, RUN, DONE; the block accepts start in IDLE and in DONE only.
REQ-014 On accept at edge k: latch a, latch b XOR {WIDTH{sub}}, carry register <= sub, bit counter <= 0, state -> RUN.
REQ-015 RUN: each edge processes one bit, LSB first, through a one-bit full adder; sum bit is shifted in at the MSB end of the result shift register; carry register <= adder carry.
REQ-016 At the edge processing bit WIDTH-1 (edge k+WIDTH): capture carry into MSB and carry out, state -> DONE.
REQ-017 Latency: done=1 exactly in the cycle following edge k+WIDTH; done is low in every other cycle.
REQ-018 busy=1 from the cycle after edge k through the cycle ending with edge k+WIDTH; busy=0 in IDLE and DONE.
REQ-019 DONE with start=0 -> IDLE at the next edge; outputs sum/c_out/overflow hold.
REQ-020 Start asserted while in RUN is ignored; no queuing, operands not re-sampled.
REQ-021 Start asserted in DONE is accepted (back-to-back); done pulses once per operation.
REQ-022 sum/c_out/overflow change only at the edge entering DONE; they are never visible partially shifted.
REQ-023 Arithmetic is modulo 2^WIDTH; a and b are not required to be stable after the accepting edge.
REQ-024 WIDTH=1: RUN lasts one cycle; overflow = carry-in XOR carry-out of that single bit.

Reset
REQ-025 rst=1 at an edge: state -> IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; counter and carry cleared.
REQ-026 Reset mid-RUN aborts the operation; no done pulse follows; start is ignored while rst=1.

Structure
REQ-027 A shared package holds the FSM state enum (IDLE, RUN, DONE) and the counter-width function clog2(WIDTH+1).
REQ-028 The per-bit arithmetic is one instance of the team's existing one-bit full-adder cell bAdd; no other sub-module is used.
REQ-029 The datapath contains no WIDTH-wide adder; WIDTH-wide shift registers and a counter only.

Verification (WIDTH=8 unless stated)
REQ-030 a=100, b=55, sub=0 -> done at cycle 9 after the accepting edge; sum=155, c_out=0, overflow=1.
REQ-031 a=200, b=100, sub=0 -> sum=44, c_out=1, overflow=0; sub=1, a=5, b=7 -> sum=0xFE, c_out=0, overflow=0.
REQ-032 sub=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, overflow=1.
REQ-033 start pulsed again at RUN cycle 3 with different operands -> ignored, first result unchanged; start held high in DONE -> second operation runs, two done pulses 9 cycles apart.
REQ-034 rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, and no done pulse within 20 cycles without a new start.
REQ-035 WIDTH=1: a=1, b=1, sub=0 -> done 2 cycles after accept, sum=0, c_out=1, overflow=1.
